// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
//   Bundles the fetch stage's memory read port, its instruction output port
//   and the redirect input into one interface.
//
//   Memory side
//     mem_read     fetch -> mem   read request, held until mem_resp
//     mem_address  fetch -> mem   word address, stable while mem_read=1
//     mem_rdata    mem -> fetch   read data, valid with mem_resp
//     mem_resp     mem -> fetch   single-cycle completion pulse
//   Instruction side
//     instr_valid  fetch -> IR    head entry holds an instruction
//     instr        fetch -> IR    head instruction word (0 when empty)
//     instr_pc     fetch -> IR    address of head word (0 when empty)
//     instr_ready  IR -> fetch    head is consumed this cycle
//   Control
//     redirect     core -> fetch  flush and restart at redirect_pc
//     redirect_pc  core -> fetch  new fetch address (bit 0 ignored)
//
//   master: the fetch unit.  slave: the surrounding core and memory.
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
    logic        mem_read;
    logic [15:0] mem_address;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;

    modport master (
        output mem_read, mem_address, instr_valid, instr, instr_pc,
        input  mem_rdata, mem_resp, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  mem_read, mem_address, instr_valid, instr, instr_pc,
        output mem_rdata, mem_resp, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//   LC-3b instruction fetch stage feeding the instruction register.
//   Owns the fetch PC, issues one word read at a time, buffers returned words
//   in a DEPTH-entry FIFO and hands them out with a valid/ready handshake.
//   A redirect flushes the FIFO and restarts fetch at a new address; a read
//   already on the bus is allowed to finish and its data is discarded.
//
//   Parameters
//     RESET_PC  fetch PC after reset (bit 0 ignored)
//     DEPTH     FIFO entries, power of two, >= 2
//
//   Ports
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    ifetch_unit_if.master (memory port, instruction port, redirect)
// ---------------------------------------------------------------------------
module ifetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    ifetch_unit_if.master  bus
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t             state_reg;
    logic [15:0]        fetch_pc_reg;
    logic               mem_read_reg;
    logic [15:0]        mem_address_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;

    logic [15:0]        data_mem [DEPTH];
    logic [15:0]        pc_mem   [DEPTH];

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    assign fifo_full  = (count_reg == (PTR_W + 1)'(DEPTH));
    assign fifo_empty = (count_reg == '0);

    // Redirect wins over both FIFO ports: the returned word is dropped and
    // the head is not consumed, since the whole FIFO is being discarded.
    assign push = (state_reg == FETCH) && bus.mem_resp && !bus.redirect;
    assign pop  = !fifo_empty && bus.instr_ready && !bus.redirect;

    // -----------------------------------------------------------------------
    // Fetch FSM, fetch PC and FIFO bookkeeping
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            fetch_pc_reg    <= RESET_PC & 16'hFFFE;
            mem_read_reg    <= 1'b0;
            mem_address_reg <= 16'h0000;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
        end else if (bus.redirect) begin
            fetch_pc_reg <= bus.redirect_pc & 16'hFFFE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            // A read still waiting on the bus cannot be withdrawn, so it is
            // carried to completion in SQUASH.  This also covers a second
            // redirect arriving while an earlier squash is still pending.
            if (mem_read_reg && !bus.mem_resp) begin
                state_reg <= SQUASH;
            end else begin
                state_reg    <= IDLE;
                mem_read_reg <= 1'b0;
            end
        end else begin
            unique case (state_reg)
                IDLE: begin
                    // Only request when there is room, so a push can never
                    // land on a full FIFO.
                    if (!fifo_full) begin
                        state_reg       <= FETCH;
                        mem_read_reg    <= 1'b1;
                        mem_address_reg <= fetch_pc_reg;
                    end
                end
                FETCH: begin
                    if (bus.mem_resp) begin
                        fetch_pc_reg <= fetch_pc_reg + 16'd2;
                        state_reg    <= IDLE;
                        mem_read_reg <= 1'b0;
                    end
                end
                SQUASH: begin
                    if (bus.mem_resp) begin
                        state_reg    <= IDLE;
                        mem_read_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    mem_read_reg <= 1'b0;
                end
            endcase

            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FIFO storage: no reset needed, entries are only visible while counted.
    // The head is read combinationally so the IR sees it in the same cycle
    // instr_valid rises.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= bus.mem_rdata;
            pc_mem[wr_ptr_reg]   <= fetch_pc_reg;
        end
    end

    assign bus.mem_read    = mem_read_reg;
    assign bus.mem_address = mem_address_reg;
    assign bus.instr_valid = !fifo_empty;
    assign bus.instr       = fifo_empty ? 16'h0000 : data_mem[rd_ptr_reg];
    assign bus.instr_pc    = fifo_empty ? 16'h0000 : pc_mem[rd_ptr_reg];

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//   Drives ifetch_unit with a behavioural memory of configurable latency and
//   an IR-side consumer.  Every accepted memory response pushes the expected
//   {instr, pc} onto a scoreboard queue; every IR load pops and compares it.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ifetch_unit;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    ifetch_unit_if bus_if ();

    ifetch_unit #(
        .RESET_PC (16'h3000),
        .DEPTH    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_q [$];
    logic [15:0] data_over [$];
    logic [15:0] exp_pc;
    logic [15:0] req_addr;
    int          age;
    int          last_age;
    int          lat;
    int          n_pops;
    bit          rdy;
    bit          rnd_mode;
    bit          red_cmd;
    logic [15:0] red_pc_cmd;
    bit          squash_pending;
    bit          post_red;
    bit          seen_zero;
    bit          hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] word_of(input logic [15:0] addr);
        return addr ^ 16'hC3A5;
    endfunction

    // One clock: observe outputs just after the edge, check them, then drive
    // the inputs that the next edge will sample and update the scoreboard.
    task automatic tick();
        logic        resp;
        logic        dropped;
        logic [15:0] data;
        logic [31:0] item;
        @(posedge clk);
        #1;
        chk("valid_vs_model", {31'd0, bus_if.instr_valid}, {31'd0, exp_q.size() != 0});
        if (post_red) begin
            chk("valid_after_redirect", {31'd0, bus_if.instr_valid}, 32'd0);
            post_red = 1'b0;
        end
        if (exp_q.size() == 0) begin
            chk("instr_empty", {16'd0, bus_if.instr}, 32'd0);
            chk("pc_empty", {16'd0, bus_if.instr_pc}, 32'd0);
        end
        if (squash_pending) chk("squash_hold", {31'd0, bus_if.mem_read}, 32'd1);

        bus_if.redirect    = red_cmd;
        bus_if.redirect_pc = red_pc_cmd;
        red_cmd            = 1'b0;
        bus_if.instr_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy;

        resp     = 1'b0;
        last_age = -1;
        if (bus_if.mem_read) begin
            last_age = age;
            if (age == 0) begin
                if (!squash_pending) chk("req_addr", {16'd0, bus_if.mem_address}, {16'd0, exp_pc});
                req_addr = bus_if.mem_address;
                if (bus_if.mem_address == 16'h0000) seen_zero = 1'b1;
            end else begin
                chk("addr_stable", {16'd0, bus_if.mem_address}, {16'd0, req_addr});
            end
            resp = (age >= lat);
            age++;
        end else begin
            age = 0;
        end

        dropped = squash_pending || bus_if.redirect;
        data    = word_of(req_addr);
        if (resp && !dropped && data_over.size() != 0) data = data_over.pop_front();
        bus_if.mem_resp  = resp;
        bus_if.mem_rdata = resp ? data : 16'($urandom);

        if (bus_if.instr_valid && bus_if.instr_ready && !bus_if.redirect && exp_q.size() != 0) begin
            item = exp_q.pop_front();
            chk("pop_instr", {16'd0, bus_if.instr}, {16'd0, item[31:16]});
            chk("pop_pc", {16'd0, bus_if.instr_pc}, {16'd0, item[15:0]});
            $display("pop pc=%h instr=%h", bus_if.instr_pc, bus_if.instr);
            n_pops++;
        end

        if (resp) begin
            if (squash_pending) begin
                squash_pending = 1'b0;
            end else if (!bus_if.redirect) begin
                exp_q.push_back({data, exp_pc});
                exp_pc = exp_pc + 16'd2;
            end
        end

        if (bus_if.redirect) begin
            if (bus_if.mem_read && !resp) squash_pending = 1'b1;
            exp_q.delete();
            exp_pc   = bus_if.redirect_pc & 16'hFFFE;
            post_red = 1'b1;
        end
    endtask

    task automatic wait_new_req(input string tag);
        for (int i = 0; i < 40 && !(bus_if.mem_read && last_age == 0 && !squash_pending); i++) tick();
        chk(tag, {31'd0, bus_if.mem_read && last_age == 0}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_pass = 0; n_pops = 0;
        age = 0; last_age = -1; lat = 1; rdy = 1'b1; rnd_mode = 1'b0;
        red_cmd = 1'b0; red_pc_cmd = 16'h0000; squash_pending = 1'b0;
        post_red = 1'b0; seen_zero = 1'b0; req_addr = 16'h0000;
        exp_pc = 16'h3000;
        rst_n = 1'b0;
        bus_if.mem_rdata = 16'h0000; bus_if.mem_resp = 1'b0;
        bus_if.instr_ready = 1'b0; bus_if.redirect = 1'b0; bus_if.redirect_pc = 16'h0000;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_read", {31'd0, bus_if.mem_read}, 32'd0);
        chk("rst_mem_address", {16'd0, bus_if.mem_address}, 32'd0);
        chk("rst_instr_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        chk("rst_instr", {16'd0, bus_if.instr}, 32'd0);
        chk("rst_instr_pc", {16'd0, bus_if.instr_pc}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First request one cycle after release, at RESET_PC
        tick();
        chk("rd_after_rst", {31'd0, bus_if.mem_read}, 32'd1);
        chk("addr_after_rst", {16'd0, bus_if.mem_address}, 32'h3000);
        for (int i = 0; i < 20 && n_pops == 0; i++) tick();
        chk("first_pop", {31'd0, n_pops != 0}, 32'd1);
        repeat (10) tick();

        // FIFO fills with the consumer stalled; no third request
        rdy = 1'b0;
        red_pc_cmd = 16'h1000; red_cmd = 1'b1;
        tick();
        data_over.push_back(16'h1234);
        data_over.push_back(16'h5678);
        for (int i = 0; i < 40 && exp_q.size() < 2; i++) tick();
        chk("fifo_filled", {31'd0, bus_if.instr_valid}, 32'd1);
        chk("head_1234", {16'd0, bus_if.instr}, 32'h1234);
        hold = 1'b0;
        repeat (10) begin
            tick();
            if (bus_if.mem_read) hold = 1'b1;
        end
        chk("no_fetch_full", {31'd0, hold}, 32'd0);
        rdy = 1'b1;
        tick();
        rdy = 1'b0;
        for (int i = 0; i < 6 && !bus_if.mem_read; i++) tick();
        chk("refetch", {31'd0, bus_if.mem_read}, 32'd1);
        chk("head_5678", {16'd0, bus_if.instr}, 32'h5678);
        rdy = 1'b1;
        repeat (20) tick();

        // Redirect while a read is outstanding; response three cycles later
        lat = 4;
        wait_new_req("t3_req_seen");
        red_pc_cmd = 16'h4001; red_cmd = 1'b1;
        tick();
        wait_new_req("t3_new_req");
        chk("t3_new_addr", {16'd0, bus_if.mem_address}, 32'h4000);
        repeat (20) tick();

        // Redirect coincident with the response
        lat = 2;
        wait_new_req("t4_req_seen");
        tick();
        red_pc_cmd = 16'h2222; red_cmd = 1'b1;
        tick();
        chk("t4_coincide", {31'd0, bus_if.mem_resp && bus_if.redirect}, 32'd1);
        wait_new_req("t4_new_req");
        chk("t4_new_addr", {16'd0, bus_if.mem_address}, 32'h2222);
        repeat (10) tick();

        // PC wraps from FFFE to 0000
        lat = 1;
        red_pc_cmd = 16'hFFFE; red_cmd = 1'b1;
        tick();
        seen_zero = 1'b0;
        repeat (20) tick();
        chk("wrap_seen", {31'd0, seen_zero}, 32'd1);

        // Streaming with single-cycle memory and an always-ready consumer
        lat = 0;
        red_pc_cmd = 16'h0100; red_cmd = 1'b1;
        tick();
        n_pops = 0;
        for (int i = 0; i < 1000 && n_pops < 100; i++) tick();
        chk("stream_100", {31'd0, n_pops >= 100}, 32'd1);

        // Random consumer stalls, latencies and redirects
        rnd_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (!bus_if.mem_read) lat = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) begin
                red_pc_cmd = 16'($urandom);
                red_cmd = 1'b1;
            end
            tick();
        end
        rnd_mode = 1'b0;
        rdy = 1'b1;
        repeat (10) tick();

        // Asynchronous reset in the middle of a fetch
        lat = 5;
        wait_new_req("t8_req_seen");
        tick();
        bus_if.mem_resp = 1'b0; bus_if.redirect = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_rst_read", {31'd0, bus_if.mem_read}, 32'd0);
        chk("async_rst_valid", {31'd0, bus_if.instr_valid}, 32'd0);
        exp_q.delete(); data_over.delete();
        age = 0; squash_pending = 1'b0; post_red = 1'b0; red_cmd = 1'b0;
        exp_pc = 16'h3000;
        @(posedge clk);
        #1;
        chk("rst_held_read", {31'd0, bus_if.mem_read}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rerst_addr", {16'd0, bus_if.mem_address}, 32'h3000);
        repeat (15) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
